// File: rtl/mat_result_streamer.sv
// Captures a packed 16x10-bit result word on a rising finish edge and streams it out one element per
// valid/ready transfer. Optional MAT_RESULT_SIGN_EXT_EN sign-extends the RES_W-bit result in each field.
module mat_result_streamer #(
    parameter int N_ELEM = 16,
    parameter int ELEM_W = 10,
    parameter int RES_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_ELEM*ELEM_W-1:0] mat_in,
    input  logic                     finish,
    output logic [ELEM_W-1:0]        out_data,
    output logic [3:0]               out_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);
    localparam int IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                     state_reg, state_next;
    logic                       finish_q_reg;
    logic [IDX_W-1:0]           idx_reg, idx_next;
    logic [N_ELEM*ELEM_W-1:0]   cap_reg, cap_next;
    logic                       overrun_reg, overrun_next;
    logic                       rise;
    logic [ELEM_W-1:0]          elem [N_ELEM];
    logic [ELEM_W-1:0]          field;
    logic [ELEM_W-1:0]          shaped;

    assign rise = finish & ~finish_q_reg;

    // Element 0 sits in the most significant field of the packed word.
    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
            assign elem[gi] = cap_reg[(N_ELEM-1-gi)*ELEM_W +: ELEM_W];
        end
    endgenerate

    assign field = elem[idx_reg];

`ifdef MAT_RESULT_SIGN_EXT_EN
    assign shaped = {{(ELEM_W-RES_W){field[RES_W-1]}}, field[RES_W-1:0]};
`else
    assign shaped = field;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            finish_q_reg <= 1'b0;
            idx_reg      <= '0;
            cap_reg      <= '0;
            overrun_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            finish_q_reg <= finish;
            idx_reg      <= idx_next;
            cap_reg      <= cap_next;
            overrun_reg  <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        cap_next     = cap_reg;
        overrun_next = overrun_reg;
        out_valid    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        out_data     = '0;
        out_idx      = '0;
        case (state_reg)
            IDLE: begin
                if (rise) begin
                    cap_next   = mat_in;
                    idx_next   = '0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_idx   = idx_reg;
                out_data  = shaped;
                // A second request while draining is dropped, only flagged.
                if (rise) begin
                    overrun_next = 1'b1;
                end
                if (out_ready) begin
                    if (idx_reg == IDX_W'(N_ELEM-1)) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
                if (rise) begin
                    overrun_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign overrun = overrun_reg;

endmodule

// File: tb/tb_mat_result_streamer.sv
// Scoreboard bench for mat_result_streamer: stimulus pushes expected transfers, a negedge monitor
// pops and compares every accepted element and every directed observation.
module tb_mat_result_streamer;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [159:0] mat_in;
    logic         finish;
    logic [9:0]   out_data;
    logic [3:0]   out_idx;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;
    logic         overrun;

    mat_result_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mat_in    (mat_in),
        .finish    (finish),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int data;
    } xfer_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } obs_t;

    xfer_t sb[$];
    obs_t  dq[$];
    int    checks = 0;
    int    errors = 0;

    // Expected out_data for a packed field.
    function automatic int ext(input int f);
`ifdef MAT_RESULT_SIGN_EXT_EN
        logic [9:0] r;
        r = 10'(f & 32'h1F);
        if (r[4]) r = r | 10'h3E0;
        return int'(r);
`else
        return f & 32'h3FF;
`endif
    endfunction

    task automatic post(input string name, input int act, input int exp);
        obs_t o;
        o.name = name;
        o.act  = act;
        o.exp  = exp;
        dq.push_back(o);
    endtask

    task automatic load(input int v[16]);
        logic [159:0] m;
        xfer_t        e;
        m = '0;
        for (int k = 0; k < 16; k++) begin
            m[159-10*k -: 10] = 10'(v[k]);
            e.idx  = k;
            e.data = ext(v[k]);
            sb.push_back(e);
        end
        mat_in = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input int t);
        int n;
        n = 0;
        while (!(out_valid && int'(out_idx) == t) && n < 40) begin
            tick();
            n++;
        end
        post("reach_idx", out_valid ? int'(out_idx) : -1, t);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        post("done_seen", int'(done), 1);
    endtask

    // Monitor / scoreboard
    initial begin
        obs_t  o;
        xfer_t e;
        forever begin
            @(negedge clk);
            while (dq.size() > 0) begin
                o = dq.pop_front();
                checks++;
                if (o.act != o.exp) begin
                    errors++;
                    $display("FAIL %s: got %0d, expected %0d", o.name, o.act, o.exp);
                end
            end
            if (rst_n) begin
                checks++;
                if (done && out_valid) begin
                    errors++;
                    $display("FAIL done_valid_overlap: done=%0b out_valid=%0b, expected not both", done, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_xfer: idx %0d data %03h, expected no transfer", out_idx, out_data);
                end else begin
                    e = sb.pop_front();
                    if (e.idx != int'(out_idx) || e.data != int'(out_data)) begin
                        errors++;
                        $display("FAIL xfer: idx %0d data %03h, expected idx %0d data %03h",
                                 out_idx, out_data, e.idx, e.data);
                    end else begin
                        $display("xfer idx %0d data %03h", out_idx, out_data);
                    end
                end
            end
        end
    end

    initial begin
        int v[16];
        int n;
        int vcnt;
        rst_n     = 1'b0;
        finish    = 1'b0;
        out_ready = 1'b0;
        mat_in    = '0;
        #2;
        post("rst_out_valid", int'(out_valid), 0);
        post("rst_busy", int'(busy), 0);
        post("rst_done", int'(done), 0);
        post("rst_overrun", int'(overrun), 0);
        post("rst_out_idx", int'(out_idx), 0);
        post("rst_out_data", int'(out_data), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic drain, then finish left high as a level
        for (int k = 0; k < 16; k++) v[k] = k + 1;
        load(v);
        out_ready = 1'b1;
        finish    = 1'b1;
        tick();
        post("cap_out_valid", int'(out_valid), 1);
        post("cap_out_idx", int'(out_idx), 0);
        post("cap_busy", int'(busy), 1);
        wait_done(n);
        post("done_cycle", n + 1, 17);
        post("done_busy", int'(busy), 0);
        vcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) vcnt++;
        end
        post("level_restream", vcnt, 0);
        post("level_overrun", int'(overrun), 0);
        post("idle_busy", int'(busy), 0);
        post("sb_empty_1", sb.size(), 0);
        finish = 1'b0;
        tick();

        // Backpressure at idx 5, mat_in changed after capture
        for (int k = 0; k < 16; k++) v[k] = 16 - k;
        load(v);
        finish = 1'b1;
        tick();
        mat_in = '1;
        finish = 1'b0;
        wait_idx(5);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            post("hold_idx", int'(out_idx), 5);
            post("hold_data", int'(out_data), ext(11));
            post("hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
        tick();
        post("after_hold_idx", int'(out_idx), 6);
        wait_done(n);
        tick();
        post("sb_empty_2", sb.size(), 0);

        // Overrun: second rise mid-stream
        for (int k = 0; k < 16; k++) v[k] = 2 * k;
        load(v);
        finish = 1'b1;
        tick();
        wait_idx(8);
        finish = 1'b0;
        tick();
        finish = 1'b1;
        tick();
        post("overrun_set", int'(overrun), 1);
        wait_done(n);
        for (int i = 0; i < 3; i++) tick();
        post("overrun_sticky", int'(overrun), 1);
        post("sb_empty_3", sb.size(), 0);
        finish = 1'b0;
        tick();

        // Asynchronous reset mid-stream
        for (int k = 0; k < 16; k++) v[k] = 15 - k;
        load(v);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        wait_idx(10);
        #2;
        rst_n = 1'b0;
        #1;
        post("arst_out_valid", int'(out_valid), 0);
        post("arst_busy", int'(busy), 0);
        post("arst_out_idx", int'(out_idx), 0);
        post("arst_overrun", int'(overrun), 0);
        sb.delete();
        tick();
        post("arst_done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        post("post_rst_done", int'(done), 0);
        post("post_rst_valid", int'(out_valid), 0);

        // Restart after reset; field 0 exercises sign extension
        v[0] = 32'h1F;
        for (int k = 1; k < 16; k++) v[k] = k;
        load(v);
        finish = 1'b1;
        tick();
        post("restart_idx", int'(out_idx), 0);
`ifdef MAT_RESULT_SIGN_EXT_EN
        post("sign_field0", int'(out_data), 32'h3FF);
`else
        post("sign_field0", int'(out_data), 32'h01F);
`endif
        wait_done(n);
        finish = 1'b0;
        tick();
        post("sb_empty_4", sb.size(), 0);
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
